// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core. It sits beside the
// F_D, ID_EX, EX_MEM and MEM_WB pipeline registers.
//
// It does three jobs:
//   - Data hazards: compares the D-stage source registers against the E and M
//     destinations. It uses the Tuse/Tnew timing model to decide when the front
//     end must stall and a bubble must be inserted into ID_EX.
//   - Forwarding: produces the bypass mux selects for the D-stage comparator
//     operands, the E-stage ALU operands and the M-stage store data.
//   - MDU sequencing: owns the multi-cycle mult/div busy sequencer. HI/LO
//     consumers in D are held until the MDU result is available.
//
// Parameters
//   MULT_CYCLES  E-stage busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   E-stage busy cycles for div/divu   (>= 1)
//   CNT_W        width of stall_cnt (only used with HAZARD_STALL_CNT_EN)
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   rsD, rtD                   D-stage source register numbers
//   tuse_rsD, tuse_rtD         cycles until D needs the operand (3 = unused)
//   rsE, rtE                   E-stage source register numbers
//   rtM                        M-stage store-data register number
//   RegWriteE/M/W, WriteRegE/M/W
//                              GPR write enable and destination per stage
//   tnewE, tnewM               cycles until the E / M result is ready
//   mdu_startE, mdu_divE       mult/div issued in E this cycle, 1 = div
//   mdu_useD                   D instruction touches the MDU or HI/LO
//   stallF, stallD, flushE     hold PC, hold F_D, bubble ID_EX
//   fwd_rsD, fwd_rtD           0 = regfile, 1 = from M, 2 = from W
//   fwd_rsE, fwd_rtE           0 = ID_EX value, 1 = from M, 2 = from W
//   fwd_rtM                    1 = forward the W result to the M store data
//   mdu_busy                   MDU sequencer busy (registered)
//   stall_cnt                  stall cycle counter (HAZARD_STALL_CNT_EN only)
//
// Configuration macro
//   HAZARD_STALL_CNT_EN  When defined, this adds the stall_cnt output. The
//                        counter increments on every cycle that stallD is
//                        high, wraps modulo 2^CNT_W and is cleared by reset.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [1:0]       tuse_rsD,
  input  logic [1:0]       tuse_rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       rtM,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic [1:0]       tnewE,
  input  logic [1:0]       tnewM,
  input  logic             mdu_startE,
  input  logic             mdu_divE,
  input  logic             mdu_useD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic [1:0]       fwd_rsD,
  output logic [1:0]       fwd_rtD,
  output logic [1:0]       fwd_rsE,
  output logic [1:0]       fwd_rtE,
  output logic             fwd_rtM,
`ifdef HAZARD_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             mdu_busy
);

  // The busy counter only has to hold the longer of the two latencies.
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int MDU_CNT_W  = $clog2(MAX_CYCLES + 1);

  localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE   = MDU_CNT_W'(1);

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  // A zero cycle count would leave the sequencer stuck at the wrap value.
  if (MULT_CYCLES < 1 || DIV_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl: MULT_CYCLES, DIV_CYCLES and CNT_W must all be >= 1");
  end

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  mdu_state_e             state_q, state_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;

  // A producer matches a source when it writes that register.
  // $0 is hard-wired to zero, so it never matches.
  function automatic logic reg_match(input logic [4:0] src,
                                     input logic       we,
                                     input logic [4:0] dst);
    return we && (dst == src) && (src != 5'd0);
  endfunction

  logic match_rsD_E, match_rsD_M, match_rsD_W;
  logic match_rtD_E, match_rtD_M, match_rtD_W;
  logic match_rsE_M, match_rsE_W;
  logic match_rtE_M, match_rtE_W;
  logic match_rtM_W;

  always_comb begin
    match_rsD_E = reg_match(rsD, RegWriteE, WriteRegE);
    match_rsD_M = reg_match(rsD, RegWriteM, WriteRegM);
    match_rsD_W = reg_match(rsD, RegWriteW, WriteRegW);
    match_rtD_E = reg_match(rtD, RegWriteE, WriteRegE);
    match_rtD_M = reg_match(rtD, RegWriteM, WriteRegM);
    match_rtD_W = reg_match(rtD, RegWriteW, WriteRegW);
    match_rsE_M = reg_match(rsE, RegWriteM, WriteRegM);
    match_rsE_W = reg_match(rsE, RegWriteW, WriteRegW);
    match_rtE_M = reg_match(rtE, RegWriteM, WriteRegM);
    match_rtE_W = reg_match(rtE, RegWriteW, WriteRegW);
    match_rtM_W = reg_match(rtM, RegWriteW, WriteRegW);
  end

  // A D-stage instruction must wait when a producer ahead of it delivers its
  // result later than the consumer needs it (Tuse < Tnew).
  // tuse = 3 marks an unused operand. Tnew never exceeds 2, so an unused
  // operand can never cause a stall.
  // W results are always ready, so W never causes a stall.
  logic data_stall;
  logic mdu_stall;
  logic stall;

  always_comb begin
    data_stall = (match_rsD_E && (tuse_rsD < tnewE)) ||
                 (match_rsD_M && (tuse_rsD < tnewM)) ||
                 (match_rtD_E && (tuse_rtD < tnewE)) ||
                 (match_rtD_M && (tuse_rtD < tnewM));
    // The start cycle itself counts: the sequencer has not yet registered busy.
    mdu_stall  = mdu_useD && ((state_q == MDU_BUSY) || mdu_startE);
    stall      = (data_stall || mdu_stall) && !reset;
  end

  // Forward selects: the M stage is younger than W, so M wins.
  // The D stage can take M only once M holds its final value (tnewM == 0).
  // Any case where M does not yet hold its final value is already stalled.
  // The E stage always takes M, because the stall logic guarantees that a
  // load in M has no consumer in E.
  always_comb begin
    fwd_rsD = FWD_NONE;
    fwd_rtD = FWD_NONE;
    fwd_rsE = FWD_NONE;
    fwd_rtE = FWD_NONE;
    fwd_rtM = 1'b0;

    if (!reset) begin
      if (match_rsD_M && (tnewM == 2'd0)) begin
        fwd_rsD = FWD_M;
      end else if (match_rsD_W) begin
        fwd_rsD = FWD_W;
      end

      if (match_rtD_M && (tnewM == 2'd0)) begin
        fwd_rtD = FWD_M;
      end else if (match_rtD_W) begin
        fwd_rtD = FWD_W;
      end

      if (match_rsE_M) begin
        fwd_rsE = FWD_M;
      end else if (match_rsE_W) begin
        fwd_rsE = FWD_W;
      end

      if (match_rtE_M) begin
        fwd_rtE = FWD_M;
      end else if (match_rtE_W) begin
        fwd_rtE = FWD_W;
      end

      fwd_rtM = match_rtM_W;
    end
  end

  always_comb begin
    stallF = stall;
    stallD = stall;
    flushE = stall;
  end

  // MDU sequencer: a start loads the latency, and the state then counts down
  // while in BUSY. The last busy cycle is the one where cnt reads 1.
  // A start that arrives while busy is ignored. The decoder never issues one,
  // because the MDU stall holds every MDU instruction in D.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      MDU_IDLE: begin
        if (mdu_startE) begin
          state_d = MDU_BUSY;
          cnt_d   = mdu_divE ? DIV_LOAD : MULT_LOAD;
        end
      end
      MDU_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = MDU_IDLE;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mdu_busy = (state_q == MDU_BUSY);
  end

`ifdef HAZARD_STALL_CNT_EN
  // Performance counter of front-end stall cycles. It wraps silently.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallD) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt = stall_cnt_q;
  end
`else
  // The stall counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl.
// Inputs change just after a rising edge. Outputs are sampled on the following
// falling edge. Every expected value below is worked out by hand from the
// Tuse/Tnew rules and the MDU latency rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;
`ifdef HAZARD_STALL_CNT_EN
   localparam int CNT_WID  = 4;
`else
   localparam int CNT_WID  = 32;
`endif

   logic       clk;
   logic       reset;
   logic [4:0] rsD, rtD, rsE, rtE, rtM;
   logic [1:0] tuse_rsD, tuse_rtD;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic [4:0] WriteRegE, WriteRegM, WriteRegW;
   logic [1:0] tnewE, tnewM;
   logic       mdu_startE, mdu_divE, mdu_useD;
   logic       stallF, stallD, flushE;
   logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
   logic       fwd_rtM;
   logic       mdu_busy;
`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_WID-1:0] stall_cnt;
`endif

   int total;
   int bad;

   hazard_ctrl #(
      .MULT_CYCLES(MULT_CYC),
      .DIV_CYCLES (DIV_CYC),
      .CNT_W      (CNT_WID)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rsD       (rsD),
      .rtD       (rtD),
      .tuse_rsD  (tuse_rsD),
      .tuse_rtD  (tuse_rtD),
      .rsE       (rsE),
      .rtE       (rtE),
      .rtM       (rtM),
      .RegWriteE (RegWriteE),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .WriteRegE (WriteRegE),
      .WriteRegM (WriteRegM),
      .WriteRegW (WriteRegW),
      .tnewE     (tnewE),
      .tnewM     (tnewM),
      .mdu_startE(mdu_startE),
      .mdu_divE  (mdu_divE),
      .mdu_useD  (mdu_useD),
      .stallF    (stallF),
      .stallD    (stallD),
      .flushE    (flushE),
      .fwd_rsD   (fwd_rsD),
      .fwd_rtD   (fwd_rtD),
      .fwd_rsE   (fwd_rsE),
      .fwd_rtE   (fwd_rtE),
      .fwd_rtM   (fwd_rtM),
`ifdef HAZARD_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .mdu_busy  (mdu_busy)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observation against its hand-computed value
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Return every input to a quiet pipeline: no writers, operands unused
   task automatic clearInputs();
      rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0; rtM = 5'd0;
      tuse_rsD = 2'd3; tuse_rtD = 2'd3;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
      tnewE = 2'd0; tnewM = 2'd0;
      mdu_startE = 1'b0; mdu_divE = 1'b0; mdu_useD = 1'b0;
   endtask

   // Let n rising edges pass, then land just after the last one
   task automatic applyStimulus(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Land on the falling edge where outputs are sampled
   task automatic sampleOutputs();
      @(negedge clk);
   endtask

   initial begin
      int stallCount;
      int busyCount;

      total = 0;
      bad   = 0;
      clearInputs();
      reset = 1'b1;

      // Reset forces the controls low even with a glaring hazard present
      applyStimulus(2);
      rsD = 5'd1; tuse_rsD = 2'd0; RegWriteE = 1'b1; WriteRegE = 5'd1; tnewE = 2'd2;
      rsE = 5'd1; RegWriteM = 1'b1; WriteRegM = 5'd1;
      sampleOutputs();
      checkOutput("rst_stallF",   32'(stallF),   32'd0);
      checkOutput("rst_flushE",   32'(flushE),   32'd0);
      checkOutput("rst_fwd_rsE",  32'(fwd_rsE),  32'd0);
      checkOutput("rst_mdu_busy", 32'(mdu_busy), 32'd0);

      // Case 1: lw $1 in E, add reading $1 in D
      applyStimulus(1);
      reset = 1'b0;
      clearInputs();
      rsD = 5'd1; tuse_rsD = 2'd1;
      RegWriteE = 1'b1; WriteRegE = 5'd1; tnewE = 2'd2;
      sampleOutputs();
      checkOutput("lw_stallF", 32'(stallF), 32'd1);
      checkOutput("lw_stallD", 32'(stallD), 32'd1);
      checkOutput("lw_flushE", 32'(flushE), 32'd1);
      // The load moves to M with a bubble behind it, and the add is still in D
      applyStimulus(1);
      clearInputs();
      rsD = 5'd1; tuse_rsD = 2'd1;
      RegWriteM = 1'b1; WriteRegM = 5'd1; tnewM = 2'd1;
      sampleOutputs();
      checkOutput("lw_m_stall",   32'(stallD),  32'd0);
      checkOutput("lw_m_fwd_rsD", 32'(fwd_rsD), 32'd0);
      // The add reaches E and the load reaches W
      applyStimulus(1);
      clearInputs();
      rsE = 5'd1;
      RegWriteW = 1'b1; WriteRegW = 5'd1;
      sampleOutputs();
      checkOutput("lw_w_fwd_rsE", 32'(fwd_rsE), 32'd2);

      // Case 2: ALU result in M feeds a beq in D
      applyStimulus(1);
      clearInputs();
      rsD = 5'd2; tuse_rsD = 2'd0; rtD = 5'd2; tuse_rtD = 2'd0;
      RegWriteM = 1'b1; WriteRegM = 5'd2; tnewM = 2'd0;
      sampleOutputs();
      checkOutput("beq_stall",   32'(stallD),  32'd0);
      checkOutput("beq_fwd_rsD", 32'(fwd_rsD), 32'd1);
      checkOutput("beq_fwd_rtD", 32'(fwd_rtD), 32'd1);

      // Case 3: M and W both write $3; M is younger and wins
      applyStimulus(1);
      clearInputs();
      rsE = 5'd3; rtE = 5'd0; rtM = 5'd3;
      RegWriteM = 1'b1; WriteRegM = 5'd3;
      RegWriteW = 1'b1; WriteRegW = 5'd3;
      sampleOutputs();
      checkOutput("prio_fwd_rsE", 32'(fwd_rsE), 32'd1);
      checkOutput("zero_fwd_rtE", 32'(fwd_rtE), 32'd0);
      checkOutput("st_fwd_rtM",   32'(fwd_rtM), 32'd1);

      // $0 written everywhere: no forward, and no stall even against a load
      applyStimulus(1);
      clearInputs();
      rsD = 5'd0; tuse_rsD = 2'd0; rsE = 5'd0;
      RegWriteE = 1'b1; WriteRegE = 5'd0; tnewE = 2'd2;
      RegWriteM = 1'b1; WriteRegM = 5'd0;
      RegWriteW = 1'b1; WriteRegW = 5'd0;
      sampleOutputs();
      checkOutput("r0_stall",   32'(stallD),  32'd0);
      checkOutput("r0_fwd_rsE", 32'(fwd_rsE), 32'd0);
      checkOutput("r0_fwd_rsD", 32'(fwd_rsD), 32'd0);

      // D takes W; store data (tuse 2) does not wait on a load in E (tnew 2)
      applyStimulus(1);
      clearInputs();
      rsD = 5'd5; tuse_rsD = 2'd1; rtD = 5'd4; tuse_rtD = 2'd2; rtM = 5'd6;
      RegWriteE = 1'b1; WriteRegE = 5'd4; tnewE = 2'd2;
      RegWriteW = 1'b1; WriteRegW = 5'd5;
      sampleOutputs();
      checkOutput("sw_no_stall", 32'(stallD),  32'd0);
      checkOutput("w_fwd_rsD",   32'(fwd_rsD), 32'd2);
      checkOutput("st_no_rtM",   32'(fwd_rtM), 32'd0);

      // A load in M still stalls a branch operand needed in D
      applyStimulus(1);
      clearInputs();
      rtD = 5'd7; tuse_rtD = 2'd0;
      RegWriteM = 1'b1; WriteRegM = 5'd7; tnewM = 2'd1;
      sampleOutputs();
      checkOutput("ldm_rt_stall", 32'(stallD), 32'd1);

      // Case 4: div issued with mflo waiting in D -> 1 + DIV_CYC stall cycles
      applyStimulus(1);
      clearInputs();
      mdu_useD = 1'b1; mdu_startE = 1'b1; mdu_divE = 1'b1;
      sampleOutputs();
      checkOutput("div_start_stall", 32'(stallD),   32'd1);
      checkOutput("div_start_busy",  32'(mdu_busy), 32'd0);
      stallCount = 1;
      busyCount  = 0;
      applyStimulus(1);
      mdu_startE = 1'b0; mdu_divE = 1'b0;
      for (int i = 1; i <= DIV_CYC + 2; i++) begin
         sampleOutputs();
         checkOutput($sformatf("div_busy_c%0d", i),  32'(mdu_busy), (i <= DIV_CYC) ? 32'd1 : 32'd0);
         checkOutput($sformatf("div_stall_c%0d", i), 32'(stallD),   (i <= DIV_CYC) ? 32'd1 : 32'd0);
         stallCount += int'(stallD);
         busyCount  += int'(mdu_busy);
         applyStimulus(1);
      end
      checkOutput("div_stall_total", 32'(stallCount), 32'd11);
      checkOutput("div_busy_total",  32'(busyCount),  32'd10);

      // Case 5: mult started, then reset pulsed during busy cycle 4
      clearInputs();
      mdu_startE = 1'b1; mdu_divE = 1'b0; mdu_useD = 1'b1;
      applyStimulus(1);
      mdu_startE = 1'b0;
      applyStimulus(3);
      sampleOutputs();
      checkOutput("mul_c4_busy", 32'(mdu_busy), 32'd1);
      applyStimulus(1);
      reset = 1'b1;
      sampleOutputs();
      checkOutput("mul_rst_stall", 32'(stallD), 32'd0);
      applyStimulus(1);
      reset = 1'b0;
      sampleOutputs();
      checkOutput("mul_abort_busy",  32'(mdu_busy), 32'd0);
      checkOutput("mul_abort_stall", 32'(stallD),   32'd0);
      applyStimulus(1);
      sampleOutputs();
      checkOutput("mul_abort_busy2", 32'(mdu_busy), 32'd0);

`ifdef HAZARD_STALL_CNT_EN
      // Case 6: a 4-bit counter wraps after 16 stalls, so 17 stalls leave 1
      applyStimulus(1);
      clearInputs();
      reset = 1'b1;
      applyStimulus(1);
      reset = 1'b0;
      sampleOutputs();
      checkOutput("cnt_after_rst", 32'(stall_cnt), 32'd0);
      applyStimulus(0);
      rsD = 5'd9; tuse_rsD = 2'd0;
      RegWriteE = 1'b1; WriteRegE = 5'd9; tnewE = 2'd1;
      applyStimulus(17);
      clearInputs();
      sampleOutputs();
      checkOutput("cnt_wrap", 32'(stall_cnt), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
